sequence_step_controller: RTL and testbench
===========================================

SEQUENCE_STEP_CONTROLLER -- requirements
Module: sequence_step_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: single-cycle pulse that begins a sequence.
REQ-004 SHALL have port stop, input, 1 bit: single-cycle pulse that aborts a sequence.
REQ-005 SHALL have port step_len, input, 32 bits: cycles per step; value 0 treated as 1.
REQ-006 SHALL have port num_steps, input, 32 bits: steps per sequence; value 0 means run until stop.
REQ-007 SHALL have port seq_data, input, 16 bits signed: next step value from the step buffer.
REQ-008 SHALL have port seq_valid, input, 1 bit: seq_data is available.
REQ-009 SHALL have port seq_ready, output, 1 bit: controller accepts seq_data this cycle.
REQ-010 SHALL have port seq, output, 16 bits signed: registered step value driving the composer seq input.
REQ-011 SHALL have port dyn_offset_disable, output, 1 bit: registered; 1 outside RUN.
REQ-012 SHALL have port disable_dac, output, 1 bit: registered; 1 outside RUN.
REQ-013 SHALL have port busy, output, 1 bit: 1 whenever state is not IDLE.
REQ-014 SHALL have port step_count, output, 32 bits: number of completed steps.
REQ-015 SHALL have port underflow, output, 1 bit: sticky flag, set on buffer starvation.

Function
REQ-016 SHALL implement states IDLE, PRIME and RUN.
REQ-017 IDLE behaviour: seq=0, seq_ready=0, disable_dac=1, dyn_offset_disable=1.
  - start: latch step_len and num_steps, clear step_count and underflow, go to PRIME.
REQ-018 PRIME behaviour: seq_ready=1.
  - On seq_valid&seq_ready: next cycle seq=seq_data, disable_dac=0, dyn_offset_disable=0, cycle counter=0, state RUN.
  - Handshake latency is exactly 1 cycle.
REQ-019 RUN behaviour: cycle counter increments each cycle; seq_ready=1 only in the cycle where counter==latched step_len-1 (the boundary cycle).
REQ-020 At a RUN boundary, step_count SHALL increment by 1 and the counter SHALL wrap to 0.
REQ-021 At a boundary with num_steps!=0 and step_count+1==num_steps, the controller SHALL go to IDLE next cycle with IDLE outputs, and SHALL deassert seq_ready in that cycle (no data consumed).
REQ-022 At a non-final boundary with seq_valid=1, seq SHALL take seq_data next cycle.
REQ-023 At a non-final boundary with seq_valid=0:
  - seq holds its previous value;
  - underflow is set;
  - the new step proceeds with the held value.
REQ-024 stop in PRIME or RUN SHALL force IDLE next cycle, with seq=0 and seq_ready=0 in the stop cycle; stop has priority over boundary, handshake and start.
REQ-025 start while busy SHALL be ignored; start and stop in the same IDLE cycle SHALL leave the controller in IDLE.
REQ-026 Changes to step_len and num_steps while busy SHALL have no effect until the next start.
REQ-027 step_count SHALL wrap from 2^32-1 to 0 silently when num_steps=0.

Reset
REQ-028 rst SHALL force, from the next edge and in any state:
  - state IDLE, seq=0, seq_ready=0;
  - disable_dac=1, dyn_offset_disable=1;
  - step_count=0, underflow=0, counter=0.
REQ-029 rst SHALL have priority over start and stop.

Configuration
REQ-030 With SEQ_UNDERFLOW_CNT_EN defined, the block SHALL add output underflow_cnt, 16 bits:
  - increments on each starved boundary;
  - saturates at 0xFFFF;
  - cleared by start and by rst.
REQ-031 Without SEQ_UNDERFLOW_CNT_EN, the port and counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-032 Package seq_ctrl_pkg SHALL hold the state enum, SEQ_W=16, CNT_W=32 and UFL_CNT_W=16.
REQ-033 The cycle counter and boundary detect SHALL be one sub-module, seq_step_timer (inputs: load, len; output: boundary pulse).

Verification
REQ-034 step_len=4, num_steps=3, values 100,200,300 always valid:
  - seq = 100 x4, 200 x4, 300 x4, then 0;
  - step_count ends at 3, underflow=0.
REQ-035 step_len=0, num_steps=2: steps of 1 cycle each, seq 5 then 6, then IDLE.
REQ-036 step_len=3, num_steps=0, seq_valid dropped at 2nd boundary:
  - seq holds the old value for the extra step;
  - underflow=1;
  - underflow_cnt=1 when the macro is enabled.
REQ-037 stop asserted mid-step in RUN: next cycle seq=0, disable_dac=1, busy=0; no extra seq_ready pulse.
REQ-038 rst during RUN with step_count=7: next cycle all outputs equal reset values; a subsequent start behaves as a fresh sequence.
REQ-039 start during RUN and start+stop together in IDLE: both ignored; state and outputs unchanged.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// Shared widths and state encoding for the sequence step controller.
package seq_ctrl_pkg;

    localparam int unsigned SEQ_W     = 16;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned UFL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/seq_step_timer.sv
// Per-step cycle counter; flags the last cycle of each step while enabled.
module seq_step_timer
    import seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] len,
    output logic             boundary
);

    logic [CNT_W-1:0] cnt;

    // len is never 0 here: the controller substitutes 1 when latching it
    assign boundary = en && (cnt == len - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= boundary ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sequence_step_controller.sv
// Steps a signed value stream out to the composer, one value per step_len cycles.
// Optional SEQ_UNDERFLOW_CNT_EN adds a saturating starved-boundary counter.
module sequence_step_controller
    import seq_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [CNT_W-1:0]        step_len,
    input  logic [CNT_W-1:0]        num_steps,
    input  logic signed [SEQ_W-1:0] seq_data,
    input  logic                    seq_valid,
    output logic                    seq_ready,
    output logic signed [SEQ_W-1:0] seq,
    output logic                    dyn_offset_disable,
    output logic                    disable_dac,
    output logic                    busy,
    output logic [CNT_W-1:0]        step_count,
    output logic                    underflow
`ifdef SEQ_UNDERFLOW_CNT_EN
    ,
    output logic [UFL_CNT_W-1:0]    underflow_cnt
`endif
);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] steps_q;
    logic             boundary;
    logic             final_step;
    logic             start_ok;
    logic             starved;

    seq_step_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state != RUN),
        .en       (state == RUN),
        .len      (len_q),
        .boundary (boundary)
    );

    assign final_step = (steps_q != '0) && (step_count + CNT_W'(1) == steps_q);
    assign start_ok   = start && !stop;
    assign starved    = (state == RUN) && !stop && boundary && !final_step && !seq_valid;
    assign busy       = (state != IDLE);

    // stop kills any handshake in its own cycle; the final boundary consumes nothing
    assign seq_ready  = !stop && ((state == PRIME) ||
                                  ((state == RUN) && boundary && !final_step));

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            seq                <= '0;
            disable_dac        <= 1'b1;
            dyn_offset_disable <= 1'b1;
            step_count         <= '0;
            underflow          <= 1'b0;
            len_q              <= CNT_W'(1);
            steps_q            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q      <= (step_len == '0) ? CNT_W'(1) : step_len;
                        steps_q    <= num_steps;
                        step_count <= '0;
                        underflow  <= 1'b0;
                        state      <= PRIME;
                    end
                end
                PRIME: begin
                    if (stop) begin
                        state <= IDLE;
                        seq   <= '0;
                    end else if (seq_valid) begin
                        seq                <= seq_data;
                        disable_dac        <= 1'b0;
                        dyn_offset_disable <= 1'b0;
                        state              <= RUN;
                    end
                end
                RUN: begin
                    if (stop || (boundary && final_step)) begin
                        state              <= IDLE;
                        seq                <= '0;
                        disable_dac        <= 1'b1;
                        dyn_offset_disable <= 1'b1;
                    end
                    if (!stop && boundary) begin
                        step_count <= step_count + CNT_W'(1);
                        if (!final_step && seq_valid) begin
                            seq <= seq_data;
                        end
                        // starved step reuses the held value
                        if (starved) begin
                            underflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    state              <= IDLE;
                    seq                <= '0;
                    disable_dac        <= 1'b1;
                    dyn_offset_disable <= 1'b1;
                end
            endcase
        end
    end

`ifdef SEQ_UNDERFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_cnt <= '0;
        end else if ((state == IDLE) && start_ok) begin
            underflow_cnt <= '0;
        end else if (starved && (underflow_cnt != '1)) begin
            underflow_cnt <= underflow_cnt + UFL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sequence_step_controller.sv
// Directed scoreboard bench for sequence_step_controller.
module tb_sequence_step_controller;

    typedef struct packed {
        logic signed [15:0] seq;
        logic               busy;
        logic               dis;
        logic               rdy;
        logic [31:0]        sc;
        logic               ufl;
        logic [15:0]        ucnt;
    } obs_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [31:0]        step_len = '0;
    logic [31:0]        num_steps = '0;
    logic signed [15:0] seq_data = '0;
    logic               seq_valid = 1'b0;
    logic               seq_ready;
    logic signed [15:0] seq;
    logic               dyn_offset_disable;
    logic               disable_dac;
    logic               busy;
    logic [31:0]        step_count;
    logic               underflow;
`ifdef SEQ_UNDERFLOW_CNT_EN
    logic [15:0]        underflow_cnt;
`endif

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    sequence_step_controller dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .stop               (stop),
        .step_len           (step_len),
        .num_steps          (num_steps),
        .seq_data           (seq_data),
        .seq_valid          (seq_valid),
        .seq_ready          (seq_ready),
        .seq                (seq),
        .dyn_offset_disable (dyn_offset_disable),
        .disable_dac        (disable_dac),
        .busy               (busy),
        .step_count         (step_count),
        .underflow          (underflow)
`ifdef SEQ_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt      (underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: one expected observation per driven cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a.seq  = seq;
            a.busy = busy;
            a.dis  = disable_dac;
            a.rdy  = seq_ready;
            a.sc   = step_count;
            a.ufl  = underflow;
`ifdef SEQ_UNDERFLOW_CNT_EN
            a.ucnt = underflow_cnt;
`else
            a.ucnt = e.ucnt;
`endif
            n_checks++;
            if ((a !== e) || (dyn_offset_disable !== e.dis)) begin
                n_fail++;
                $display("FAIL obs t=%0t got seq=%0d busy=%b dis=%b dyn=%b rdy=%b sc=%0d ufl=%b ucnt=%0d want seq=%0d busy=%b dis=%b rdy=%b sc=%0d ufl=%b ucnt=%0d",
                         $time, a.seq, a.busy, a.dis, dyn_offset_disable, a.rdy, a.sc, a.ufl, a.ucnt,
                         e.seq, e.busy, e.dis, e.rdy, e.sc, e.ufl, e.ucnt);
            end
        end
    end

    // Drive one cycle of inputs and queue what the DUT should show in that cycle
    task automatic drive(input logic st, input logic sp, input logic r, input logic v,
                         input logic signed [15:0] d,
                         input logic signed [15:0] es, input logic eb, input logic ed,
                         input logic er, input logic [31:0] esc, input logic eu,
                         input logic [15:0] euc);
        obs_t e;
        @(posedge clk);
        #1;
        start     = st;
        stop      = sp;
        rst       = r;
        seq_valid = v;
        seq_data  = d;
        e.seq  = es;
        e.busy = eb;
        e.dis  = ed;
        e.rdy  = er;
        e.sc   = esc;
        e.ufl  = eu;
        e.ucnt = euc;
        exp_q.push_back(e);
    endtask

    initial begin
        logic signed [15:0] vals [4];
        vals = '{16'sd100, 16'sd200, 16'sd300, 16'sd0};
        repeat (2) @(posedge clk);

        // len=4, 3 steps, always valid; first check is the reset state
        step_len  = 32'd4;
        num_steps = 32'd3;
        drive(1, 0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 100,  0, 1, 1, 1, 0, 0, 0);
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) begin
                drive(0, 0, 0, 1, (s < 2) ? vals[s+1] : 16'sd0,
                      vals[s], 1, 0, (k == 3) && (s < 2), 32'(s), 0, 0);
            end
        end

        // len=0 behaves as 1, 2 steps
        step_len  = 32'd0;
        num_steps = 32'd2;
        drive(1, 0, 0, 0, 0,    0, 0, 1, 0, 3, 0, 0);
        drive(0, 0, 0, 1, 5,    0, 1, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 6,    5, 1, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 7,    6, 1, 0, 0, 1, 0, 0);

        // len=3, free-running, starved at second boundary, then stop mid-step
        step_len  = 32'd3;
        num_steps = 32'd0;
        drive(1, 0, 0, 0, 0,    0, 0, 1, 0, 2, 0, 0);
        drive(0, 0, 0, 1, 10,   0, 1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 20, 10, 1, 0, k == 2, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, k != 2, (k != 2) ? 16'sd20 : 16'sd0,
                                          20, 1, 0, k == 2, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, 30, 20, 1, 0, k == 2, 2, 1, 1);
        drive(0, 0, 0, 0, 0,    30, 1, 0, 0, 3, 1, 1);
        drive(0, 1, 0, 1, 40,   30, 1, 0, 0, 3, 1, 1);
        drive(0, 0, 0, 1, 40,   0, 0, 1, 0, 3, 1, 1);
        drive(0, 0, 0, 0, 0,    0, 0, 1, 0, 3, 1, 1);

        // len=1 free-running, reset while RUN with step_count=7
        step_len  = 32'd1;
        num_steps = 32'd0;
        drive(1, 0, 0, 0, 0,    0, 0, 1, 0, 3, 1, 1);
        drive(0, 0, 0, 1, 1,    0, 1, 1, 1, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            drive(0, 0, j == 7, 1, 16'(j + 2), 16'(j + 1), 1, 0, 1, 32'(j), 0, 0);
        end
        drive(0, 0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0);

        // fresh start; start and config changes while busy must be ignored
        step_len  = 32'd2;
        num_steps = 32'd2;
        drive(1, 0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 42,   0, 1, 1, 1, 0, 0, 0);
        step_len  = 32'd9;
        num_steps = 32'd5;
        drive(1, 0, 0, 1, 43,   42, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 43,   42, 1, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 44,   43, 1, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 44,   43, 1, 0, 0, 1, 0, 0);

        // start together with stop in IDLE stays IDLE
        drive(1, 1, 0, 1, 50,   0, 0, 1, 0, 2, 0, 0);
        drive(0, 0, 0, 1, 50,   0, 0, 1, 0, 2, 0, 0);
        drive(0, 0, 0, 0, 0,    0, 0, 1, 0, 2, 0, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
